// File: rtl/shift_register_sequencer.sv
// Sequencer for an external N-bit universal shift register: loads a word, shifts it out
// one bit per DIV-cycle period while shifting sin in, then presents the received word.
module shift_register_sequencer #(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] tx_data,
    input  logic         msb_first,
    input  logic         abort,
    input  logic         sin,
    output logic         sout,
    output logic         busy,
    output logic         rx_valid,
    output logic [N-1:0] rx_data,
    output logic [1:0]   sr_ctrl,
    output logic [N-1:0] sr_d,
    input  logic [N-1:0] sr_q,
    output logic [1:0]   state_dbg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(N);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          dir_q, dir_d;
    logic [N-1:0]  data_q, data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [N-1:0]  rx_data_q, rx_data_d;
    logic [N-1:0]  shifted;

    // Handshake: a request is taken on any edge where start_valid && start_ready.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        bit_d      = bit_q;
        dir_d      = dir_q;
        data_d     = data_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        sr_ctrl    = 2'b00;
        sr_d       = '0;
        sout       = 1'b0;
        // Register contents after the current shift; captured on the final shift so
        // rx_data is already valid while rx_valid is high.
        shifted    = dir_q ? {sr_q[N-2:0], sin} : {sin, sr_q[N-1:1]};

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    data_d  = tx_data;
                    dir_d   = msb_first;
                    presc_d = '0;
                    bit_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sr_ctrl = 2'b11;
                    sr_d    = data_q;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sout = dir_q ? sr_q[N-1] : sr_q[0];
                if (abort) begin
                    presc_d = '0;
                    bit_d   = '0;
                    state_d = IDLE;
                end else if (presc_q == PRESC_LAST) begin
                    sr_ctrl = dir_q ? 2'b01 : 2'b10;
                    sr_d    = {{(N-1){1'b0}}, sin};
                    presc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d      = '0;
                        rx_valid_d = 1'b1;
                        rx_data_d  = shifted;
                        state_d    = DONE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            bit_q      <= '0;
            dir_q      <= 1'b0;
            data_q     <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            bit_q      <= bit_d;
            dir_q      <= dir_d;
            data_q     <= data_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench for shift_register_sequencer: two instances (DIV=4 and DIV=1) driving behavioural
// shift registers, checked every cycle against a transfer-timeline model plus literal pins.
module tb_shift_register_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   start_valid, msb_first, abort, sin, sin_drv, loop;
    logic [1:0]   start_ready, sout, busy, rx_valid;
    logic [N-1:0] tx_data [2];
    logic [N-1:0] rx_data [2];
    logic [N-1:0] sr_d    [2];
    logic [N-1:0] sr_q    [2];
    logic [1:0]   sr_ctrl [2];
    logic [1:0]   state_dbg [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign sin[0] = loop[0] ? sout[0] : sin_drv[0];
    assign sin[1] = loop[1] ? sout[1] : sin_drv[1];

    shift_register_sequencer #(.N(N), .DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .start_valid(start_valid[0]), .start_ready(start_ready[0]),
        .tx_data(tx_data[0]), .msb_first(msb_first[0]), .abort(abort[0]), .sin(sin[0]),
        .sout(sout[0]), .busy(busy[0]), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
        .sr_ctrl(sr_ctrl[0]), .sr_d(sr_d[0]), .sr_q(sr_q[0]), .state_dbg(state_dbg[0])
    );

    shift_register_sequencer #(.N(N), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .start_valid(start_valid[1]), .start_ready(start_ready[1]),
        .tx_data(tx_data[1]), .msb_first(msb_first[1]), .abort(abort[1]), .sin(sin[1]),
        .sout(sout[1]), .busy(busy[1]), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
        .sr_ctrl(sr_ctrl[1]), .sr_d(sr_d[1]), .sr_q(sr_q[1]), .state_dbg(state_dbg[1])
    );

    // External universal shift registers; serial input enters through d[0].
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q[0] <= '0;
            sr_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (sr_ctrl[i])
                    2'b01:   sr_q[i] <= {sr_q[i][N-2:0], sr_d[i][0]};
                    2'b10:   sr_q[i] <= {sr_d[i][0], sr_q[i][N-1:1]};
                    2'b11:   sr_q[i] <= sr_d[i];
                    default: ;
                endcase
            end
        end
    end

    function automatic int divof(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Cycle c counts from 1 (load cycle) after the accepting edge; bit periods start at c=2.
    function automatic bit is_strobe(int c, int d);
        return (c >= 2) && (c <= 1 + N * d) && (((c - 2) % d) == d - 1);
    endfunction

    function automatic logic [N-1:0] shift_in(logic [N-1:0] a, logic s, logic dir);
        return dir ? {a[N-2:0], s} : {s, a[N-1:1]};
    endfunction

    // Transfer-timeline model.
    logic         m_active [2];
    int           m_cyc    [2];
    logic [N-1:0] m_word   [2];
    logic         m_dir    [2];
    logic [N-1:0] m_acc    [2];
    logic [N-1:0] m_rx_exp [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] <= 1'b0;
                m_cyc[i]    <= 0;
                m_word[i]   <= '0;
                m_dir[i]    <= 1'b0;
                m_acc[i]    <= '0;
                m_rx_exp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_active[i]) begin
                    if (start_valid[i]) begin
                        m_active[i] <= 1'b1;
                        m_cyc[i]    <= 1;
                        m_word[i]   <= tx_data[i];
                        m_dir[i]    <= msb_first[i];
                        m_acc[i]    <= '0;
                    end
                end else if (m_cyc[i] == 2 + N * divof(i)) begin
                    m_active[i] <= 1'b0;
                end else if (abort[i]) begin
                    m_active[i] <= 1'b0;
                end else begin
                    if (is_strobe(m_cyc[i], divof(i))) begin
                        m_acc[i] <= shift_in(m_acc[i], sin[i], m_dir[i]);
                        if (m_cyc[i] == 1 + N * divof(i))
                            m_rx_exp[i] <= shift_in(m_acc[i], sin[i], m_dir[i]);
                    end
                    m_cyc[i] <= m_cyc[i] + 1;
                end
            end
        end
    end

    task automatic check(string name, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int           d;
            int           c;
            int           s;
            int           b;
            logic [1:0]   e_ctrl;
            logic [N-1:0] e_d;
            logic         e_sout;
            bit           chk_d;
            d      = divof(i);
            c      = m_cyc[i];
            e_ctrl = 2'b00;
            e_d    = '0;
            e_sout = 1'b0;
            chk_d  = 1'b0;
            if (m_active[i] && c == 1) begin
                e_ctrl = abort[i] ? 2'b00 : 2'b11;
                chk_d  = !abort[i];
                e_d    = m_word[i];
            end
            if (m_active[i] && c >= 2 && c <= 1 + N * d) begin
                s      = c - 2;
                b      = s / d;
                e_sout = m_dir[i] ? m_word[i][N-1-b] : m_word[i][b];
                if (is_strobe(c, d) && !abort[i]) begin
                    e_ctrl = m_dir[i] ? 2'b01 : 2'b10;
                    chk_d  = 1'b1;
                    e_d    = {{(N-1){1'b0}}, sin[i]};
                end
            end
            check("start_ready", i, 32'(start_ready[i]), 32'(!m_active[i]));
            check("busy", i, 32'(busy[i]), 32'(m_active[i]));
            check("sr_ctrl", i, 32'(sr_ctrl[i]), 32'(e_ctrl));
            check("sout", i, 32'(sout[i]), 32'(e_sout));
            check("rx_valid", i, 32'(rx_valid[i]), 32'(m_active[i] && c == 2 + N * d));
            check("rx_data", i, 32'(rx_data[i]), 32'(m_rx_exp[i]));
            if (chk_d) check("sr_d", i, 32'(sr_d[i]), 32'(e_d));
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            compare_all();
            @(posedge clk);
            #1;
        end
    endtask

    // smode: 0 loopback, 1 sin held at 1, 2 sin from pat (pat[N-1] is the first bit).
    // exp_lat=0 marks an aborted transfer: no rx_valid, rx_data must still equal exp_rx.
    task automatic xfer(int i, logic [N-1:0] word, logic dir, int smode, logic [N-1:0] pat,
                        int abort_at, int sv_at, logic [N-1:0] exp_rx, int exp_lat,
                        logic exp_first);
        int d;
        int nd;
        int n_rx;
        int s;
        d    = divof(i);
        nd   = N * d;
        n_rx = 0;
        tx_data[i]     = word;
        msb_first[i]   = dir;
        loop[i]        = (smode == 0);
        sin_drv[i]     = (smode == 1);
        start_valid[i] = 1'b1;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        tx_data[i]   = ~word;
        msb_first[i] = ~dir;
        for (int c = 1; c <= nd + 3; c++) begin
            start_valid[i] = (sv_at > 0) && (c == sv_at || c == nd + 2);
            abort[i]       = (c == abort_at);
            if (smode == 2) begin
                s = c - 2;
                if (s >= 0 && s / d < N) sin_drv[i] = pat[N-1-(s/d)];
            end
            @(negedge clk);
            compare_all();
            if (rx_valid[i]) n_rx++;
            if (c == 1) check("lit_load_ctrl", i, 32'(sr_ctrl[i]), 32'd3);
            if (c == 2) check("lit_first_sout", i, 32'(sout[i]), 32'(exp_first));
            if (c == exp_lat) begin
                check("lit_rx_valid", i, 32'(rx_valid[i]), 32'd1);
                check("lit_rx_data", i, 32'(rx_data[i]), 32'(exp_rx));
            end
            if (sv_at > 0 && c == sv_at) check("lit_ready_busy", i, 32'(start_ready[i]), 32'd0);
            if (abort_at > 0 && c == abort_at + 1) begin
                check("lit_abort_busy", i, 32'(busy[i]), 32'd0);
                check("lit_abort_ready", i, 32'(start_ready[i]), 32'd1);
                check("lit_abort_ctrl", i, 32'(sr_ctrl[i]), 32'd0);
                check("lit_abort_sout", i, 32'(sout[i]), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        start_valid[i] = 1'b0;
        abort[i]       = 1'b0;
        check("lit_rx_count", i, 32'(n_rx), (exp_lat > 0) ? 32'd1 : 32'd0);
        if (exp_lat == 0) check("lit_rx_held", i, 32'(rx_data[i]), 32'(exp_rx));
    endtask

    task automatic check_reset_values(int i);
        check("rst_ready", i, 32'(start_ready[i]), 32'd1);
        check("rst_busy", i, 32'(busy[i]), 32'd0);
        check("rst_ctrl", i, 32'(sr_ctrl[i]), 32'd0);
        check("rst_sr_d", i, 32'(sr_d[i]), 32'd0);
        check("rst_sout", i, 32'(sout[i]), 32'd0);
        check("rst_rx_valid", i, 32'(rx_valid[i]), 32'd0);
        check("rst_rx_data", i, 32'(rx_data[i]), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = '0;
        msb_first   = '0;
        abort       = '0;
        sin_drv     = '0;
        loop        = '0;
        tx_data[0]  = '0;
        tx_data[1]  = '0;
        @(posedge clk);
        #1;
        check_reset_values(0);
        check_reset_values(1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        xfer(0, 8'hA5, 1'b1, 0, 8'h00, 0, 0, 8'hA5, 34, 1'b1);
        idle(1);
        xfer(0, 8'h01, 1'b0, 1, 8'h00, 0, 0, 8'hFF, 34, 1'b1);
        idle(1);
        xfer(1, 8'h3C, 1'b1, 2, 8'hC3, 0, 0, 8'hC3, 10, 1'b0);
        idle(1);
        xfer(0, 8'h5A, 1'b1, 0, 8'h00, 0, 12, 8'h5A, 34, 1'b0);
        idle(1);
        // Abort lands on the shift cycle of bit 3 (c = 2 + 3*4 + 3).
        xfer(0, 8'h33, 1'b0, 0, 8'h00, 17, 0, 8'h5A, 0, 1'b1);
        idle(1);

        tx_data[0]     = 8'h96;
        msb_first[0]   = 1'b1;
        loop[0]        = 1'b1;
        start_valid[0] = 1'b1;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        start_valid[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            compare_all();
            if (c == 10) check("lit_mid_busy", 0, 32'(busy[0]), 32'd1);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check_reset_values(0);
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        xfer(0, 8'h81, 1'b0, 0, 8'h00, 0, 0, 8'h81, 34, 1'b1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
